// File: rtl/platform_tracker.sv
// Player/obstacle tracker: scrolls the level, scans blocks once per frame and climbs/drops the player.
// Optional crash detection is enabled with `define PLATFORM_TRACKER_DEATH_EN.
module platform_tracker #(
  parameter int NUM_BLOCKS = 27,
  parameter int COORD_W    = 11,
  parameter int PLAYER_X   = 59,
  parameter int GROUND_Y   = 99,
  parameter int STEP       = 10,
  parameter int HIT_HALF   = 9,
  parameter int IDX_W      = 5
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          update_screen,
  input  logic [COORD_W-1:0]            move_step,
  input  logic                          jump_pressed,
  input  logic [NUM_BLOCKS*COORD_W-1:0] block_x_pos,
  input  logic [NUM_BLOCKS*COORD_W-1:0] block_y_pos,
  input  logic [NUM_BLOCKS-1:0]         block_valid,
  output logic [COORD_W-1:0]            square_x_pos,
  output logic [COORD_W-1:0]            square_y_pos,
  output logic [COORD_W-1:0]            scroll,
  output logic                          scan_busy,
  output logic                          scan_done,
  output logic                          on_block,
  output logic [IDX_W-1:0]              block_index,
  output logic                          scan_overrun,
  output logic                          dead
);

  // state | meaning
  // IDLE  | waiting for the next frame strobe
  // SCAN  | evaluating one block per clock
  // DEAD  | crashed; everything frozen until reset
  typedef enum logic [1:0] {IDLE, SCAN, DEAD} state_t;

  localparam logic [COORD_W-1:0] PLAYER_C = COORD_W'(PLAYER_X);
  localparam logic [COORD_W-1:0] GROUND_C = COORD_W'(GROUND_Y);
  localparam logic [COORD_W-1:0] STEP_C   = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] WIN_LO   = COORD_W'(PLAYER_X - HIT_HALF);
  localparam logic [COORD_W-1:0] WIN_HI   = COORD_W'(PLAYER_X + HIT_HALF);
  localparam logic [IDX_W-1:0]   LAST_K   = IDX_W'(NUM_BLOCKS - 1);

  state_t state, state_next;

  logic [IDX_W-1:0]   scan_k;
  logic               acc_support, acc_same, acc_found;
  logic [IDX_W-1:0]   acc_idx;
  logic               climb_pending;

  logic [COORD_W-1:0] blk_x, blk_y, rel_x, y_up;
  logic [COORD_W:0]   y_fall_wide;
  logic [COORD_W-1:0] y_fall;
  logic               blk_ok, near, same, support, last;
  logic               any_same, any_support, any_near, crash, climb_ok;
  logic [IDX_W-1:0]   idx_final;
  logic               frame, step, commit;

  // Per-block evaluation for the block currently addressed by scan_k
  always_comb begin
    blk_x       = block_x_pos[scan_k*COORD_W +: COORD_W];
    blk_y       = block_y_pos[scan_k*COORD_W +: COORD_W];
    blk_ok      = block_valid[scan_k];
    rel_x       = blk_x - scroll;
    y_up        = square_y_pos + STEP_C;
    near        = blk_ok && (rel_x >= WIN_LO) && (rel_x <= WIN_HI);
    same        = near && (blk_y == square_y_pos);
    support     = near && (blk_y == y_up);
    last        = (scan_k == LAST_K);
    any_same    = acc_same | same;
    any_support = acc_support | support;
    any_near    = acc_found | near;
    idx_final   = acc_found ? acc_idx : scan_k;
`ifdef PLATFORM_TRACKER_DEATH_EN
    crash       = any_same && !jump_pressed;
`else
    crash       = 1'b0;
`endif
    climb_ok    = any_same && (square_y_pos >= STEP_C) && !crash;
    y_fall_wide = {1'b0, square_y_pos} + {1'b0, STEP_C};
    y_fall      = (y_fall_wide > {1'b0, GROUND_C}) ? GROUND_C : y_fall_wide[COORD_W-1:0];
    frame       = update_screen && (state != DEAD);
    step        = (state == SCAN) && !update_screen;
    commit      = step && last;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (update_screen) state_next = SCAN;
      SCAN: begin
        if (update_screen)  state_next = SCAN;
        else if (last)      state_next = crash ? DEAD : IDLE;
      end
      DEAD:    state_next = DEAD;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    scan_busy = (state == SCAN);
`ifdef PLATFORM_TRACKER_DEATH_EN
    dead      = (state == DEAD);
`else
    dead      = 1'b0;
`endif
  end

  assign square_x_pos = PLAYER_C;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      square_y_pos  <= GROUND_C;
      scroll        <= '0;
      scan_k        <= '0;
      acc_support   <= 1'b0;
      acc_same      <= 1'b0;
      acc_found     <= 1'b0;
      acc_idx       <= '0;
      on_block      <= 1'b1;
      block_index   <= '0;
      scan_done     <= 1'b0;
      scan_overrun  <= 1'b0;
      climb_pending <= 1'b0;
    end else begin
      scan_done <= commit;
      if (frame) begin
        if (state == SCAN) scan_overrun <= 1'b1;
        if (climb_pending) begin
          square_y_pos  <= square_y_pos - STEP_C;
          climb_pending <= 1'b0;
        end else if (!on_block && (square_y_pos < GROUND_C) && !jump_pressed) begin
          square_y_pos <= y_fall;
        end
        scroll      <= scroll + move_step;
        scan_k      <= '0;
        acc_support <= 1'b0;
        acc_same    <= 1'b0;
        acc_found   <= 1'b0;
        acc_idx     <= '0;
      end else if (step) begin
        acc_support <= any_support;
        acc_same    <= any_same;
        acc_found   <= any_near;
        acc_idx     <= idx_final;
        scan_k      <= last ? '0 : scan_k + 1'b1;
        if (last) begin
          on_block      <= any_support || (square_y_pos == GROUND_C);
          if (any_near) block_index <= idx_final;
          climb_pending <= climb_ok;
        end
      end
    end
  end

endmodule

// File: tb/tb_platform_tracker.sv
// Scoreboard bench for platform_tracker: strobes push expected scan results, a monitor checks each scan_done.
module tb_platform_tracker;
  localparam int N  = 27;
  localparam int CW = 11;
  localparam int IW = 5;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            update_screen = 1'b0;
  logic [CW-1:0]   move_step = '0;
  logic            jump_pressed = 1'b0;
  logic [N*CW-1:0] block_x_pos = '0;
  logic [N*CW-1:0] block_y_pos = '0;
  logic [N-1:0]    block_valid = '0;
  logic [CW-1:0]   square_x_pos, square_y_pos, scroll;
  logic            scan_busy, scan_done, on_block, scan_overrun, dead;
  logic [IW-1:0]   block_index;

  platform_tracker dut (
    .clock(clock), .reset(reset), .update_screen(update_screen),
    .move_step(move_step), .jump_pressed(jump_pressed),
    .block_x_pos(block_x_pos), .block_y_pos(block_y_pos), .block_valid(block_valid),
    .square_x_pos(square_x_pos), .square_y_pos(square_y_pos), .scroll(scroll),
    .scan_busy(scan_busy), .scan_done(scan_done), .on_block(on_block),
    .block_index(block_index), .scan_overrun(scan_overrun), .dead(dead)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic          ob;
    logic [IW-1:0] idx;
    logic [CW-1:0] y;
    logic [CW-1:0] sc;
    int            t;
  } exp_t;
  exp_t sbq[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every scan_done must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (scan_done) begin
      if (sbq.size() == 0) begin
        check("unexpected_scan_done", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("done_latency", cyc - e.t, N);
        check("on_block", int'(on_block), int'(e.ob));
        check("block_index", int'(block_index), int'(e.idx));
        check("square_y_pos", int'(square_y_pos), int'(e.y));
        check("scroll", int'(scroll), int'(e.sc));
        check("busy_at_done", int'(scan_busy), 0);
      end
    end
  end

  task automatic set_block(input int k, input int x, input int y, input logic v);
    block_x_pos[k*CW +: CW] = CW'(x);
    block_y_pos[k*CW +: CW] = CW'(y);
    block_valid[k] = v;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Strobe one frame; when push is set, the given post-scan values are expected
  task automatic strobe(input int mv, input logic jp, input bit push,
                        input logic ob, input int idx, input int y, input int sc);
    exp_t e;
    @(negedge clock);
    move_step = CW'(mv);
    jump_pressed = jp;
    update_screen = 1'b1;
    @(posedge clock);
    #1;
    update_screen = 1'b0;
    if (push) begin
      e.ob = ob; e.idx = IW'(idx); e.y = CW'(y); e.sc = CW'(sc); e.t = cyc;
      sbq.push_back(e);
      check("busy_after_strobe", int'(scan_busy), 1);
      check("y_after_strobe", int'(square_y_pos), y);
      check("scroll_after_strobe", int'(scroll), sc);
    end
  endtask

  task automatic drain();
    int budget = 80;
    while (sbq.size() != 0 && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (sbq.size() != 0) begin
      check("scan_done_timeout", sbq.size(), 0);
      sbq.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    do_reset();
    check("rst_y", int'(square_y_pos), 99);
    check("rst_x", int'(square_x_pos), 59);
    check("rst_scroll", int'(scroll), 0);
    check("rst_on_block", int'(on_block), 1);
    check("rst_index", int'(block_index), 0);
    check("rst_busy", int'(scan_busy), 0);
    check("rst_done", int'(scan_done), 0);
    check("rst_overrun", int'(scan_overrun), 0);
    check("rst_dead", int'(dead), 0);

    // Empty level, constant scroll
    for (int i = 1; i <= 3; i++) begin
      strobe(2, 1'b0, 1, 1'b1, 0, 99, 2 * i);
      drain();
    end

    // Climb onto block 5 at player level (jump held so the crash build also climbs)
    do_reset();
    set_block(5, 64, 99, 1'b1);
    strobe(0, 1'b1, 1, 1'b1, 5, 99, 0);
    drain();
    strobe(0, 1'b0, 1, 1'b1, 5, 89, 0);
    drain();

    // Scroll block 5 out of the window: support lost, fall gated by jump
    strobe(20, 1'b0, 1, 1'b0, 5, 89, 20);
    drain();
    strobe(0, 1'b1, 1, 1'b0, 5, 89, 20);
    drain();
    strobe(0, 1'b0, 1, 1'b1, 5, 99, 20);
    drain();

    // Scroll wrap: block 3 at x=61 seen at rel_x=59 after wrap
    do_reset();
    block_valid = '0;
    strobe(2046, 1'b0, 1, 1'b1, 0, 99, 2046);
    drain();
    set_block(3, 61, 50, 1'b1);
    strobe(4, 1'b0, 1, 1'b1, 3, 99, 2);
    drain();

    // Overrun: second strobe 10 cycles into a scan
    check("overrun_before", int'(scan_overrun), 0);
    strobe(0, 1'b0, 0, 1'b0, 0, 0, 0);
    repeat (9) @(posedge clock);
    strobe(1, 1'b0, 1, 1'b1, 3, 99, 3);
    check("overrun_set", int'(scan_overrun), 1);
    check("overrun_on_block_held", int'(on_block), 1);
    check("overrun_index_held", int'(block_index), 3);
    drain();
    check("overrun_sticky", int'(scan_overrun), 1);

`ifdef PLATFORM_TRACKER_DEATH_EN
    do_reset();
    block_valid = '0;
    set_block(3, 61, 99, 1'b1);
    strobe(0, 1'b0, 1, 1'b1, 3, 99, 0);
    drain();
    check("dead_set", int'(dead), 1);
    strobe(5, 1'b0, 0, 1'b0, 0, 0, 0);
    repeat (40) @(negedge clock);
    check("dead_y_frozen", int'(square_y_pos), 99);
    check("dead_scroll_frozen", int'(scroll), 0);
    check("dead_not_busy", int'(scan_busy), 0);
    check("dead_sticky", int'(dead), 1);
    do_reset();
    check("dead_cleared", int'(dead), 0);
`else
    check("dead_tied_low", int'(dead), 0);
`endif

    repeat (5) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
